// File: rtl/omsp_spm_mgr_pkg.sv
// omsp_spm_mgr_pkg: shared defaults, FSM encodings and range helpers for the protected-module manager
package omsp_spm_mgr_pkg;
    localparam int NB_SPMS_DEF = 4;
    localparam int ID_W_DEF    = 16;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;
    // Scan index width; a single slot still needs a one-bit index register
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    // Half-open ranges [a_s, a_e) and [b_s, b_e) share at least one address
    function automatic logic ranges_overlap(input logic [15:0] a_s, input logic [15:0] a_e,
                                            input logic [15:0] b_s, input logic [15:0] b_e);
        return (a_s < b_e) && (b_s < a_e);
    endfunction
endpackage

// File: rtl/omsp_spm_slot.sv
// omsp_spm_slot: one protected-module slot holding its layout, with access, PC and overlap checks
module omsp_spm_slot
    import omsp_spm_mgr_pkg::*;
#(
    parameter int ID_W          = ID_W_DEF,
    parameter bit PROTECT_READS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en_i,
    input  logic            clr_en_i,
    input  logic [15:0]     req_pub_s_i,
    input  logic [15:0]     req_pub_e_i,
    input  logic [15:0]     req_sec_s_i,
    input  logic [15:0]     req_sec_e_i,
    input  logic [ID_W-1:0] req_id_i,
    input  logic [15:0]     cur_pc_i,
    input  logic [15:0]     eu_mab_i,
    input  logic            eu_mb_en_i,
    input  logic [1:0]      eu_mb_wr_i,
    output logic            en_o,
    output logic [ID_W-1:0] id_o,
    output logic            hit_o,
    output logic            pc_in_pub_o,
    output logic            ovl_o
);
    logic            en_q;
    logic [15:0]     pub_s_q, pub_e_q, sec_s_q, sec_e_q;
    logic [ID_W-1:0] id_q;

    // Layout loads on commit; destroy drops only the enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= 1'b0;
            pub_s_q <= '0;
            pub_e_q <= '0;
            sec_s_q <= '0;
            sec_e_q <= '0;
            id_q    <= '0;
        end else if (wr_en_i) begin
            en_q    <= 1'b1;
            pub_s_q <= req_pub_s_i;
            pub_e_q <= req_pub_e_i;
            sec_s_q <= req_sec_s_i;
            sec_e_q <= req_sec_e_i;
            id_q    <= req_id_i;
        end else if (clr_en_i) begin
            en_q <= 1'b0;
        end
    end

    assign en_o        = en_q;
    assign id_o        = id_q;
    assign pc_in_pub_o = (cur_pc_i >= pub_s_q) && (cur_pc_i < pub_e_q);
    assign hit_o       = en_q && eu_mb_en_i && (eu_mab_i >= sec_s_q) && (eu_mab_i < sec_e_q)
                         && (PROTECT_READS || (eu_mb_wr_i != 2'b00)) && !pc_in_pub_o;
    assign ovl_o       = en_q && (ranges_overlap(req_pub_s_i, req_pub_e_i, pub_s_q, pub_e_q)
                               || ranges_overlap(req_pub_s_i, req_pub_e_i, sec_s_q, sec_e_q)
                               || ranges_overlap(req_sec_s_i, req_sec_e_i, pub_s_q, pub_e_q)
                               || ranges_overlap(req_sec_s_i, req_sec_e_i, sec_s_q, sec_e_q));
endmodule

// File: rtl/omsp_spm_mgr.sv
// omsp_spm_mgr: Sancus protected-module manager with handshaked create/destroy FSM and access checking
module omsp_spm_mgr
    import omsp_spm_mgr_pkg::*;
#(
    parameter int NB_SPMS       = NB_SPMS_DEF,
    parameter int ID_W          = ID_W_DEF,
    parameter bit PROTECT_READS = 1'b1
) (
    input  logic               mclk,
    input  logic               puc_rst,
    input  logic [15:0]        pc,
    input  logic               decode,
    input  logic [15:0]        eu_mab,
    input  logic               eu_mb_en,
    input  logic [1:0]         eu_mb_wr,
    input  logic               req_valid,
    input  logic               req_enable,
    input  logic [15:0]        r12,
    input  logic [15:0]        r13,
    input  logic [15:0]        r14,
    input  logic [15:0]        r15,
    output logic               req_busy,
    output logic               rsp_valid,
    output logic               rsp_ok,
    output logic [ID_W-1:0]    rsp_id,
    output logic [NB_SPMS-1:0] spm_enabled,
    output logic               violation,
    output logic [3:0]         violation_slot,
    output logic [15:0]        violation_addr,
    output logic               viol_sticky,
    input  logic               viol_clr
);
    localparam int IW = idx_w(NB_SPMS);

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [ID_W-1:0]    id_cnt_q, rsp_id_q, rsp_id_d, dst_id;
    logic               rsp_ok_q, rsp_ok_d;
    logic [15:0]        cur_pc_q, pub_s_q, pub_e_q, sec_s_q, sec_e_q;
    logic [NB_SPMS-1:0] hit, pin, ovl, free_oh, dst_oh;
    logic [ID_W-1:0]    ids [NB_SPMS];
    logic               free_any, dst_found, create_acc, destroy_acc, pre_bad;
    logic               viol_q, viol_sticky_q;
    logic [3:0]         hit_idx, viol_slot_q;
    logic [15:0]        viol_addr_q;

    assign create_acc  = (state_q == ST_IDLE) && req_valid && req_enable;
    assign destroy_acc = (state_q == ST_IDLE) && req_valid && !req_enable;
    assign pre_bad     = (r12 >= r13) || (r14 >= r15) || ranges_overlap(r12, r13, r14, r15)
                         || !free_any || (id_cnt_q == '0);

    genvar g;
    generate
        for (g = 0; g < NB_SPMS; g++) begin : g_slot
            omsp_spm_slot #(.ID_W(ID_W), .PROTECT_READS(PROTECT_READS)) u_slot (
                .clk         (mclk),
                .rst         (puc_rst),
                .wr_en_i     ((state_q == ST_COMMIT) && free_oh[g]),
                .clr_en_i    (destroy_acc && dst_oh[g]),
                .req_pub_s_i (pub_s_q),
                .req_pub_e_i (pub_e_q),
                .req_sec_s_i (sec_s_q),
                .req_sec_e_i (sec_e_q),
                .req_id_i    (id_cnt_q),
                .cur_pc_i    (cur_pc_q),
                .eu_mab_i    (eu_mab),
                .eu_mb_en_i  (eu_mb_en),
                .eu_mb_wr_i  (eu_mb_wr),
                .en_o        (spm_enabled[g]),
                .id_o        (ids[g]),
                .hit_o       (hit[g]),
                .pc_in_pub_o (pin[g]),
                .ovl_o       (ovl[g])
            );
        end
    endgenerate

    // Lowest-index priority: first free slot, destroy target and violating slot
    always_comb begin
        free_oh   = '0;
        free_any  = 1'b0;
        dst_oh    = '0;
        dst_found = 1'b0;
        dst_id    = '0;
        hit_idx   = '0;
        for (int i = NB_SPMS - 1; i >= 0; i--) begin
            if (!spm_enabled[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
                free_any   = 1'b1;
            end
            if (spm_enabled[i] && pin[i]) begin
                dst_oh    = '0;
                dst_oh[i] = 1'b1;
                dst_found = 1'b1;
                dst_id    = ids[i];
            end
            if (hit[i]) hit_idx = 4'(i);
        end
    end

    // Request FSM next state; response fields are only non-zero while in RESP
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rsp_ok_d = rsp_ok_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_enable && !pre_bad) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                end else if (req_valid) begin
                    state_d  = ST_RESP;
                    rsp_ok_d = !req_enable && dst_found;
                    rsp_id_d = req_enable ? '0 : dst_id;
                end
            end
            ST_SCAN: begin
                if (ovl[idx_q]) state_d = ST_RESP;
                else if (idx_q == IW'(NB_SPMS - 1)) state_d = ST_COMMIT;
                else idx_d = idx_q + IW'(1);
            end
            ST_COMMIT: begin
                state_d  = ST_RESP;
                rsp_ok_d = 1'b1;
                rsp_id_d = id_cnt_q;
            end
            default: begin
                state_d  = ST_IDLE;
                rsp_ok_d = 1'b0;
                rsp_id_d = '0;
            end
        endcase
    end

    // FSM, response and ID counter; the counter wrapping to zero marks exhaustion
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rsp_ok_q <= 1'b0;
            rsp_id_q <= '0;
            id_cnt_q <= ID_W'(1);
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rsp_ok_q <= rsp_ok_d;
            rsp_id_q <= rsp_id_d;
            if (state_q == ST_COMMIT) id_cnt_q <= id_cnt_q + ID_W'(1);
        end
    end

    // Current PC follows decode strobes; create ranges are captured at accept
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            cur_pc_q <= '0;
            pub_s_q  <= '0;
            pub_e_q  <= '0;
            sec_s_q  <= '0;
            sec_e_q  <= '0;
        end else begin
            if (decode) cur_pc_q <= pc;
            if (create_acc) begin
                pub_s_q <= r12;
                pub_e_q <= r13;
                sec_s_q <= r14;
                sec_e_q <= r15;
            end
        end
    end

    // Registered violation report; slot and address hold until the next hit, set beats clear
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            viol_q        <= 1'b0;
            viol_slot_q   <= '0;
            viol_addr_q   <= '0;
            viol_sticky_q <= 1'b0;
        end else begin
            viol_q        <= |hit;
            viol_sticky_q <= (|hit) || (viol_sticky_q && !viol_clr);
            if (|hit) begin
                viol_slot_q <= hit_idx;
                viol_addr_q <= eu_mab;
            end
        end
    end

    assign req_busy       = (state_q != ST_IDLE);
    assign rsp_valid      = (state_q == ST_RESP);
    assign rsp_ok         = rsp_ok_q;
    assign rsp_id         = rsp_id_q;
    assign violation      = viol_q;
    assign violation_slot = viol_slot_q;
    assign violation_addr = viol_addr_q;
    assign viol_sticky    = viol_sticky_q;
endmodule
